// File: rtl/axi_fb_mem.sv
// AXI4 subordinate backing the framebuffer with a single-port block RAM.
// Write and read INCR bursts are arbitrated round-robin and fully serialised.
module axi_fb_mem #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      s_axi_awvalid_i,
    output logic                      s_axi_awready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr_i,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid_i,
    input  logic [7:0]                s_axi_awlen_i,
    input  logic [2:0]                s_axi_awsize_i,
    input  logic [1:0]                s_axi_awburst_i,

    input  logic                      s_axi_wvalid_i,
    output logic                      s_axi_wready_o,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata_i,
    input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb_i,
    input  logic                      s_axi_wlast_i,

    output logic                      s_axi_bvalid_o,
    input  logic                      s_axi_bready_i,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid_o,
    output logic [1:0]                s_axi_bresp_o,

    input  logic                      s_axi_arvalid_i,
    output logic                      s_axi_arready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr_i,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid_i,
    input  logic [7:0]                s_axi_arlen_i,
    input  logic [2:0]                s_axi_arsize_i,
    input  logic [1:0]                s_axi_arburst_i,

    output logic                      s_axi_rvalid_o,
    input  logic                      s_axi_rready_i,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid_o,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata_o,
    output logic [1:0]                s_axi_rresp_o,
    output logic                      s_axi_rlast_o
);

    localparam int WORD_LSB = $clog2(AXI_STRB_WIDTH);
    localparam int WORD_AW  = AXI_ADDR_WIDTH - WORD_LSB;
    localparam int DEPTH    = 1 << WORD_AW;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ
    } state_e;

    state_e state_q, state_d;

    logic                      prio_wr_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [7:0]                len_q;
    logic [WORD_AW-1:0]        word_q;
    logic [8:0]                cnt_q;
    logic                      err_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic                      rvalid_q;
    logic                      rlast_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    logic aw_sel, ar_sel;
    logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic w_last_beat, rd_en;

    // Burst attributes are fixed to INCR at full width, so these fields carry no information.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize_i, s_axi_awburst_i, s_axi_arsize_i, s_axi_arburst_i,
                         s_axi_awaddr_i, s_axi_araddr_i};

    // With both channels requesting, the priority holder wins; a lone request always wins.
    assign aw_sel = s_axi_awvalid_i && (!s_axi_arvalid_i || prio_wr_q);
    assign ar_sel = s_axi_arvalid_i && !aw_sel;

    assign aw_hs       = s_axi_awvalid_i && s_axi_awready_o;
    assign ar_hs       = s_axi_arvalid_i && s_axi_arready_o;
    assign w_hs        = s_axi_wvalid_i && s_axi_wready_o;
    assign b_hs        = bvalid_q && s_axi_bready_i;
    assign r_hs        = rvalid_q && s_axi_rready_i;
    assign w_last_beat = (cnt_q[7:0] == len_q);
    assign rd_en       = (state_q == S_READ) && (cnt_q <= {1'b0, len_q}) &&
                         (!rvalid_q || s_axi_rready_i);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        s_axi_awready_o = 1'b0;
        s_axi_arready_o = 1'b0;
        s_axi_wready_o  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // No grant may complete while reset is held.
                s_axi_awready_o = rst_n && aw_sel;
                s_axi_arready_o = rst_n && ar_sel;
                if (aw_hs)      state_d = S_WRITE;
                else if (ar_hs) state_d = S_READ;
            end
            S_WRITE: begin
                s_axi_wready_o = 1'b1;
                if (w_hs && w_last_beat) state_d = S_WRESP;
            end
            S_WRESP: if (b_hs) state_d = S_IDLE;
            S_READ:  if (r_hs && rlast_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            len_q     <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (aw_hs || ar_hs) begin
                prio_wr_q <= !prio_wr_q;
                id_q      <= aw_hs ? s_axi_awid_i : s_axi_arid_i;
                len_q     <= aw_hs ? s_axi_awlen_i : s_axi_arlen_i;
                word_q    <= aw_hs ? s_axi_awaddr_i[AXI_ADDR_WIDTH-1:WORD_LSB]
                                   : s_axi_araddr_i[AXI_ADDR_WIDTH-1:WORD_LSB];
                cnt_q     <= '0;
                err_q     <= 1'b0;
            end

            // The burst length, not wlast, terminates a write; a misplaced wlast only flags an error.
            if (w_hs) begin
                word_q <= word_q + WORD_AW'(1);
                cnt_q  <= cnt_q + 9'd1;
                err_q  <= err_q || (s_axi_wlast_i != w_last_beat);
                if (w_last_beat) begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= (err_q || !s_axi_wlast_i) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            if (b_hs) bvalid_q <= 1'b0;

            if (rd_en) begin
                rdata_q  <= mem[word_q];
                rlast_q  <= (cnt_q[7:0] == len_q);
                rvalid_q <= 1'b1;
                word_q   <= word_q + WORD_AW'(1);
                cnt_q    <= cnt_q + 9'd1;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // NOTE: the RAM array has no reset, so contents survive rst_n and it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (s_axi_wstrb_i[b]) mem[word_q][8*b +: 8] <= s_axi_wdata_i[8*b +: 8];
            end
        end
    end

    assign s_axi_bvalid_o = bvalid_q;
    assign s_axi_bresp_o  = bresp_q;
    assign s_axi_bid_o    = id_q;
    assign s_axi_rvalid_o = rvalid_q;
    assign s_axi_rdata_o  = rdata_q;
    assign s_axi_rlast_o  = rlast_q;
    assign s_axi_rresp_o  = RESP_OKAY;
    assign s_axi_rid_o    = id_q;

endmodule

// File: doc/axi_fb_mem.md
# axi_fb_mem

AXI4 subordinate that backs the graphics framebuffer with on-chip block RAM, sitting at the far end of the framebuffer AXI bus. It accepts INCR write bursts from the pixel writer and INCR read bursts from the scan-out reader, and serialises both onto one single-port RAM. It is used both as a simulation memory model and as the synthesised framebuffer on targets without external SDRAM.

## Interface
- AXI_ADDR_WIDTH, 16: byte address width.
- AXI_DATA_WIDTH, 32: data width; a multiple of 8.
- AXI_ID_WIDTH, 4: transaction ID width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8: byte strobe width.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- s_axi_awvalid/awready  in/out  1  write address handshake.
- s_axi_awaddr  in  AXI_ADDR_WIDTH; s_axi_awid  in  AXI_ID_WIDTH; s_axi_awlen  in  8; s_axi_awsize  in  3; s_axi_awburst  in  2.
- s_axi_wvalid/wready  in/out  1; s_axi_wdata  in  AXI_DATA_WIDTH; s_axi_wstrb  in  AXI_STRB_WIDTH; s_axi_wlast  in  1.
- s_axi_bvalid/bready  out/in  1; s_axi_bid  out  AXI_ID_WIDTH; s_axi_bresp  out  2.
- s_axi_arvalid/arready  in/out  1; s_axi_araddr  in  AXI_ADDR_WIDTH; s_axi_arid  in  AXI_ID_WIDTH; s_axi_arlen  in  8; s_axi_arsize  in  3; s_axi_arburst  in  2.
- s_axi_rvalid/rready  out/in  1; s_axi_rid  out  AXI_ID_WIDTH; s_axi_rdata  out  AXI_DATA_WIDTH; s_axi_rresp  out  2; s_axi_rlast  out  1.

## Operation
- RAM: 2^(AXI_ADDR_WIDTH - log2(AXI_STRB_WIDTH)) words. Word index = addr >> log2(AXI_STRB_WIDTH); low address bits are ignored. The word index increments by 1 per beat and wraps modulo the depth.
- awsize, arsize and the burst fields are ignored; every burst is treated as INCR at full data width.
- States:
  - IDLE -> WRITE on AW handshake; latch id, len and word address.
  - IDLE -> READ on AR handshake; latch id, len and word address.
  - WRITE -> WRESP after beat len+1 is accepted.
  - WRESP -> IDLE on the B handshake.
  - READ -> IDLE on the R handshake of the last beat.
- Arbitration in IDLE:
  - awready and arready are asserted only in IDLE, and only one at a time. Only the selected channel's ready is asserted.
  - If both awvalid and arvalid are high, the priority holder wins. Priority toggles after every granted burst. Writes hold priority after reset.
  - If only one valid is high, that channel wins regardless of priority.
- Write:
  - wready is high throughout WRITE.
  - Each W handshake writes the bytes selected by wstrb to the current word.
  - wlast is checked: it must be 1 exactly on beat len+1. Any mismatch sets a sticky error for the burst.
  - The burst always ends after len+1 beats, independent of wlast.
  - bresp = 2'b10 (SLVERR) on error, else 2'b00. bid = latched id.
- Read:
  - RAM read enable = state==READ && beats_remaining && (!rvalid || rready).
  - rdata is the registered RAM output; rvalid is set the cycle after a read enable and held until the R handshake.
  - rlast = 1 on beat len+1. rresp is always 2'b00. rid = latched id.
- The write side has no read-during-write hazard; bursts are strictly serialised.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, bid=0, arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0. State = IDLE; priority = write.
- A reset mid-burst abandons the burst: no B or R response is issued. RAM contents are preserved.
- Write path:
  - AW handshake on cycle N; wready is high from N+1.
  - Sustained throughput is 1 beat/cycle.
  - bvalid rises in the cycle after the final W handshake.
  - The next address ready can assert, at earliest, in the cycle after the B handshake.
- Read path:
  - AR handshake on cycle N; first rvalid in N+2.
  - With rready held high, one beat per cycle with no bubbles.
  - When rready is low, rvalid, rdata and rlast hold stable.
- awlen=0 and arlen=0 are single-beat bursts: rlast and the wlast check both apply to beat 1.

## Test plan
- Write 4-beat burst to 0x0100 (awlen=3, data 0xA0..0xA3, strb 0xF, correct wlast), then read 4 beats from 0x0100 -> rdata A0,A1,A2,A3; rlast only on beat 4; bresp=0; bid/rid echo 0x5.
- Partial strobe: write 0x11223344 with strb 0xF, then 0xAABBCCDD with strb 0x5 to the same address, then read -> 0x11BB33DD.
- awvalid and arvalid asserted in the same cycle, twice in a row, starting after reset -> order is write, read, write, read.
- Read 8 beats with rready toggling 1,0,1,0 -> each beat is held while rready=0; no beat is lost or duplicated; rlast on beat 8 only.
- 2-beat write with wlast high on beat 1 -> two RAM writes; bresp=2'b10. The next clean burst returns bresp=0.
- Write at the top word with awlen=1, then read 2 beats from the top word -> the second beat comes from word 0 (wrap-around). Assert rst_n low mid-read -> rvalid=0 the next cycle; a post-reset read returns the written data.
